// File: rtl/mem_ctrl.sv
// Byte-wide RAM sequencer serving instruction fetches (4 bytes) and data loads/stores (1/2/4 bytes).
// Data accesses win over fetches; a jump redirect abandons an in-flight fetch.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ife_i,
  input  logic [31:0] if_addr_i,
  input  logic        reorder_i,
  output logic        ifready_o,
  output logic [31:0] ifdata_o,
  input  logic        meme_i,
  input  logic        memwr_i,
  input  logic [31:0] memaddr_i,
  input  logic [1:0]  memsel_i,
  input  logic [31:0] memwdata_i,
  output logic        memready_o,
  output logic [31:0] memrdata_o,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_wr,
  input  logic [7:0]  mem_din
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] IF_BUSY  = 2'd1;
  localparam logic [1:0] MEM_BUSY = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic        ifready_q, ifready_d;
  logic        memready_q, memready_d;
  logic [31:0] ifdata_q, ifdata_d;
  logic [31:0] memrdata_q, memrdata_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;

  logic [2:0]  lane;
  logic [2:0]  next_off;
  logic [31:0] next_addr;
  logic [31:0] rbuf_merge;
  logic [2:0]  sel_len;

  always_comb begin
    case (memsel_i)
      2'b00:   sel_len = 3'd1;
      2'b01:   sel_len = 3'd2;
      default: sel_len = 3'd4;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    rbuf_d     = rbuf_q;
    ifready_d  = 1'b0;
    memready_d = 1'b0;
    ifdata_d   = ifdata_q;
    memrdata_d = memrdata_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;

    // cnt holds the offset of the address on mem_a; mem_din carries the byte at offset cnt-1
    lane       = cnt_q - 3'd1;
    next_off   = cnt_q + 3'd1;
    next_addr  = base_q + {29'd0, next_off};
    rbuf_merge = rbuf_q;
    if (cnt_q != 3'd0) rbuf_merge[{lane[1:0], 3'b000} +: 8] = mem_din;

    case (state_q)
      IDLE: begin
        if (meme_i) begin
          state_d    = MEM_BUSY;
          cnt_d      = 3'd0;
          len_d      = sel_len;
          base_d     = memaddr_i;
          wdata_d    = memwdata_i;
          wr_d       = memwr_i;
          rbuf_d     = 32'd0;
          mem_a_d    = memaddr_i;
          mem_wr_d   = memwr_i;
          mem_dout_d = memwdata_i[7:0];
        end else if (ife_i) begin
          state_d    = IF_BUSY;
          cnt_d      = 3'd0;
          len_d      = 3'd4;
          base_d     = if_addr_i;
          wr_d       = 1'b0;
          rbuf_d     = 32'd0;
          mem_a_d    = if_addr_i;
          mem_wr_d   = 1'b0;
        end
      end
      IF_BUSY, MEM_BUSY: begin
        if (state_q == IF_BUSY && reorder_i) begin
          state_d  = IDLE;
          cnt_d    = 3'd0;
          mem_wr_d = 1'b0;
        end else if (wr_q) begin
          if (cnt_q == len_q - 3'd1) begin
            state_d    = DONE;
            cnt_d      = 3'd0;
            mem_wr_d   = 1'b0;
            memready_d = 1'b1;
          end else begin
            cnt_d      = next_off;
            mem_a_d    = next_addr;
            mem_dout_d = wdata_q[{next_off[1:0], 3'b000} +: 8];
          end
        end else begin
          rbuf_d = rbuf_merge;
          if (cnt_q == len_q) begin
            state_d = DONE;
            cnt_d   = 3'd0;
            if (state_q == IF_BUSY) begin
              ifready_d = 1'b1;
              ifdata_d  = rbuf_merge;
            end else begin
              memready_d = 1'b1;
              memrdata_d = rbuf_merge;
            end
          end else begin
            cnt_d = next_off;
            if (next_off < len_q) mem_a_d = next_addr;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      len_q      <= 3'd0;
      base_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wr_q       <= 1'b0;
      rbuf_q     <= 32'd0;
      ifready_q  <= 1'b0;
      memready_q <= 1'b0;
      ifdata_q   <= 32'd0;
      memrdata_q <= 32'd0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rbuf_q     <= rbuf_d;
      ifready_q  <= ifready_d;
      memready_q <= memready_d;
      ifdata_q   <= ifdata_d;
      memrdata_q <= memrdata_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  assign ifready_o  = ifready_q;
  assign ifdata_o   = ifdata_q;
  assign memready_o = memready_q;
  assign memrdata_o = memrdata_q;
  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign mem_wr     = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM responder plus a transaction-level reference (byte array + latency rules).
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ife_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        reorder_i = 1'b0;
  logic        ifready_o;
  logic [31:0] ifdata_o;
  logic        meme_i = 1'b0;
  logic        memwr_i = 1'b0;
  logic [31:0] memaddr_i = '0;
  logic [1:0]  memsel_i = '0;
  logic [31:0] memwdata_i = '0;
  logic        memready_o;
  logic [31:0] memrdata_o;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din = '0;

  int n_chk = 0;
  int n_err = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .ife_i(ife_i), .if_addr_i(if_addr_i), .reorder_i(reorder_i),
    .ifready_o(ifready_o), .ifdata_o(ifdata_o),
    .meme_i(meme_i), .memwr_i(memwr_i), .memaddr_i(memaddr_i),
    .memsel_i(memsel_i), .memwdata_i(memwdata_i),
    .memready_o(memready_o), .memrdata_o(memrdata_o),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  // Environment RAM (4 KiB window, upper address bits alias) and the reference copy.
  logic [7:0] ram [0:4095];
  logic [7:0] ref_mem [0:4095];

  always @(posedge clk) begin
    mem_din <= ram[mem_a[11:0]];
    if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    ram[a[11:0]]     = d;
    ref_mem[a[11:0]] = d;
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] w = '0;
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      t = a + i;
      w = w | ({24'd0, ref_mem[t[11:0]]} << (8 * i));
    end
    return w;
  endfunction

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    logic [31:0] w = '0;
    logic [31:0] t;
    for (int i = 0; i < 4; i++) begin
      t = a + i;
      w = w | ({24'd0, ram[t[11:0]]} << (8 * i));
    end
    return w;
  endfunction

  task automatic drop_req();
    ife_i      = 1'b0;
    meme_i     = 1'b0;
    memwr_i    = 1'b0;
    memsel_i   = 2'($urandom);
    if_addr_i  = $urandom;
    memaddr_i  = $urandom;
    memwdata_i = $urandom;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  // rc != 0 pulses reorder_i during cycle rc after acceptance.
  task automatic run_txn(input bit fetch, input bit wr, input logic [1:0] sel,
                         input logic [31:0] addr, input logic [31:0] wdata, input int rc);
    int n;
    int lat;
    bit aborted;
    bit is_st;
    logic [31:0] exp;
    logic [31:0] t;
    n       = fetch ? 4 : (sel == 2'b00 ? 1 : (sel == 2'b01 ? 2 : 4));
    is_st   = !fetch && wr;
    aborted = fetch && rc >= 1 && rc <= 5;
    lat     = aborted ? 0 : (is_st ? n + 1 : n + 2);
    exp     = ref_word(addr, n);
    if (fetch) begin
      ife_i = 1'b1; if_addr_i = addr;
    end else begin
      meme_i = 1'b1; memwr_i = wr; memaddr_i = addr; memsel_i = sel; memwdata_i = wdata;
    end
    @(posedge clk);
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      if (j == 1) drop_req();
      check("ready", fetch ? ifready_o : memready_o, 32'(j == lat));
      check("other_ready", fetch ? memready_o : ifready_o, 0);
      check("mem_wr", mem_wr, 32'(is_st && j <= n));
      if (j <= n && (!aborted || j <= rc)) check("mem_a", mem_a, addr + j - 1);
      if (is_st && j <= n) check("mem_dout", mem_dout, (wdata >> (8 * (j - 1))) & 32'hFF);
      if (!is_st && j == lat) check("rdata", fetch ? ifdata_o : memrdata_o, exp);
      reorder_i = (j == rc);
    end
    reorder_i = 1'b0;
    if (!is_st && !aborted) check("rdata_hold", fetch ? ifdata_o : memrdata_o, exp);
    if (is_st) begin
      for (int i = 0; i < n; i++) begin
        t = addr + i;
        ref_mem[t[11:0]] = wdata[8*i +: 8];
      end
      check("store_ram", ram_word(addr), ref_word(addr, 4));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    int kind;
    int rc;
    int n;

    for (int i = 0; i < 4096; i++) poke(i, 8'($urandom));

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ifready", ifready_o, 0);
    check("rst_memready", memready_o, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_dout", mem_dout, 0);
    check("rst_ifdata", ifdata_o, 0);
    check("rst_memrdata", memrdata_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // Fetch of a known word
    poke(32'h100, 8'h13); poke(32'h101, 8'h00); poke(32'h102, 8'h50); poke(32'h103, 8'h00);
    run_txn(1, 0, 2'b00, 32'h100, 0, 0);
    check("fetch_word", ifdata_o, 32'h00500013);

    // Halfword store
    run_txn(0, 1, 2'b01, 32'h20, 32'hAABBCCDD, 0);
    check("st_byte0", ram[12'h020], 32'hDD);
    check("st_byte1", ram[12'h021], 32'hCC);

    // Simultaneous requests: load wins, fetch accepted the cycle after DONE
    poke(32'h40, 8'h9C);
    ife_i = 1'b1; if_addr_i = 32'h200;
    meme_i = 1'b1; memwr_i = 1'b0; memaddr_i = 32'h40; memsel_i = 2'b00;
    @(posedge clk);
    for (int j = 1; j <= 13; j++) begin
      @(negedge clk);
      if (j == 1) begin meme_i = 1'b0; memaddr_i = $urandom; end
      if (j == 5) ife_i = 1'b0;
      check("prio_memready", memready_o, 32'(j == 3));
      check("prio_ifready", ifready_o, 32'(j == 10));
      if (j == 3) check("prio_load", memrdata_o, 32'h0000009C);
      if (j >= 5 && j <= 8) check("prio_fetch_a", mem_a, 32'h200 + j - 5);
      if (j == 10) check("prio_fetch", ifdata_o, ref_word(32'h200, 4));
    end

    // Redirect mid-fetch with a new fetch request pending
    ife_i = 1'b1; if_addr_i = 32'h0;
    @(posedge clk);
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (j == 1) ife_i = 1'b0;
      check("redir_ifready", ifready_o, 32'(j == 10));
      check("redir_memready", memready_o, 0);
      if (j == 10) check("redir_data", ifdata_o, ref_word(32'h80, 4));
      if (j == 3) begin reorder_i = 1'b1; ife_i = 1'b1; if_addr_i = 32'h80; end
      if (j == 4) reorder_i = 1'b0;
      if (j == 5) ife_i = 1'b0;
    end

    // Redirect in the final capture cycle
    run_txn(1, 0, 2'b00, 32'h140, 0, 5);

    // Address wrap
    run_txn(1, 0, 2'b00, 32'hFFFFFFFE, 0, 0);

    // Reset in cycle 3 of a word store, then a request in the first cycle after reset
    wd = $urandom;
    meme_i = 1'b1; memwr_i = 1'b1; memsel_i = 2'b10; memaddr_i = 32'h300; memwdata_i = wd;
    @(posedge clk);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      if (j == 1) drop_req();
      check("rst_st_wr", mem_wr, 1);
      check("rst_st_a", mem_a, 32'h300 + j - 1);
      check("rst_st_rdy", memready_o, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_wr", mem_wr, 0);
    check("rst_mid_rdy", memready_o, 0);
    check("rst_mid_a", mem_a, 0);
    for (int i = 0; i < 3; i++) ref_mem[12'h300 + i] = wd[8*i +: 8];
    check("rst_mid_ram", ram_word(32'h300), ref_word(32'h300, 4));
    rst = 1'b0;
    run_txn(0, 0, 2'b10, 32'h300, 0, 0);

    // Randomized mix
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 2);
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = 32'hFFFFFFFC + $urandom_range(0, 3);
        default: a = 32'h1000 + $urandom_range(0, 63);
      endcase
      wd = $urandom;
      memsel_i = 2'($urandom);
      n = (kind == 0) ? 4 : (memsel_i == 2'b00 ? 1 : (memsel_i == 2'b01 ? 2 : 4));
      rc = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n + 2) : 0;
      run_txn(kind == 0, kind == 2, memsel_i, a, wd, rc);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
